// File: rtl/mips_ex_pkg.sv
// mips_ex_pkg
// Shared definitions for the MIPS-Lite EX-stage units.
//   - Signal opcodes used to select HI/LO reads onto an EX unit's data output.
//   - The multiply controller state type.
// No ports: this is a package imported by the EX units.
package mips_ex_pkg;

    // Read-select opcodes carried on the 3-bit Signal bus
    localparam logic [2:0] SIG_MFHI = 3'b110;
    localparam logic [2:0] SIG_MFLO = 3'b111;

    // Iterative multiplier controller states
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } multu_state_t;

    // True when the opcode is a HI/LO register read
    function automatic logic is_hilo_read(input logic [2:0] sig);
        return (sig == SIG_MFHI) || (sig == SIG_MFLO);
    endfunction

endpackage

// File: rtl/multu_step.sv
// multu_step
// Combinational single iteration of the unsigned shift-add multiplier.
// The running product holds the partial sum in its upper half and the
// not-yet-retired multiplier bits in its lower half.
// Build option: MULTU_RADIX4_EN retires two multiplier bits per call
// instead of one (WIDTH must then be even).
// Ports:
//   mcand     in  WIDTH    multiplicand
//   prod      in  2*WIDTH  current running product
//   prod_next out 2*WIDTH  running product after this iteration
module multu_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]   mcand,
    input  logic [2*WIDTH-1:0] prod,
    output logic [2*WIDTH-1:0] prod_next
);

`ifdef MULTU_RADIX4_EN
    logic [WIDTH+1:0] sum;
    logic [WIDTH+1:0] add_lo;
    logic [WIDTH+1:0] add_hi;

    // Two partial products at once; the sum needs two guard bits because
    // upper + 3*mcand can reach almost 4*2^WIDTH. The shift by two drops
    // the two multiplier bits just consumed.
    always_comb begin
        add_lo    = prod[0] ? {2'b00, mcand} : '0;
        add_hi    = prod[1] ? {1'b0, mcand, 1'b0} : '0;
        sum       = {2'b00, prod[2*WIDTH-1:WIDTH]} + add_lo + add_hi;
        prod_next = {sum, prod[WIDTH-1:2]};
    end
`else
    logic [WIDTH:0] sum;
    logic [WIDTH:0] addend;

    // The carry out of the add becomes the new MSB after the shift, so no
    // product bit is ever lost.
    always_comb begin
        addend    = prod[0] ? {1'b0, mcand} : '0;
        sum       = {1'b0, prod[2*WIDTH-1:WIDTH]} + addend;
        prod_next = {sum, prod[WIDTH-1:1]};
    end
`endif

endmodule

// File: rtl/multu_unit.sv
// multu_unit
// Multi-cycle unsigned multiplier (MULTU) for the EX stage, with the HI/LO
// register pair and the MFHI/MFLO read mux.
// Build option: MULTU_RADIX4_EN halves the iteration count (two multiplier
// bits per RUN cycle); results are identical either way.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset
//   start    in   one-cycle MULTU request, honoured only in IDLE
//   dataA    in   WIDTH  multiplicand (rs)
//   dataB    in   WIDTH  multiplier (rt)
//   Signal   in   3      read-select opcode (MFHI/MFLO)
//   busy     out  operation in progress
//   done     out  one-cycle pulse, HI/LO just loaded
//   hi, lo   out  WIDTH  registered result halves
//   dataOut  out  WIDTH  hi/lo selected by Signal, else zero
module multu_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic [2:0]       Signal,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] dataOut
);

    import mips_ex_pkg::*;

`ifdef MULTU_RADIX4_EN
    localparam int ITERS = WIDTH / 2;
`else
    localparam int ITERS = WIDTH;
`endif
    localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERS - 1);

    multu_state_t       state;
    multu_state_t       state_next;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_next;
    logic               last_iter;

    multu_step #(.WIDTH(WIDTH)) u_step (
        .mcand     (mcand),
        .prod      (prod),
        .prod_next (prod_next)
    );

    // The iteration that leaves RUN is the one processing the final count
    always_comb begin
        last_iter = (state == RUN) && (cnt == LAST_CNT);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and status outputs; DONE always lasts exactly one cycle
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture, iteration and result load. HI/LO are written only on
    // the final iteration so reads during a multiply see the previous result.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            mcand <= '0;
            prod  <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand <= dataA;
                        prod  <= {{WIDTH{1'b0}}, dataB};
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    prod <= prod_next;
                    cnt  <= cnt + CNT_W'(1);
                    if (last_iter) begin
                        hi <= prod_next[2*WIDTH-1:WIDTH];
                        lo <= prod_next[WIDTH-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Zero-latency read mux shared with the other EX units' result path
    always_comb begin
        dataOut = '0;
        if (is_hilo_read(Signal)) begin
            dataOut = (Signal == SIG_MFHI) ? hi : lo;
        end
    end

endmodule

// File: tb/tb_multu_unit.sv
// tb_multu_unit
// Self-checking bench for multu_unit: directed corner operands, randomized
// operands against an arithmetic product model, busy/done timing, operand
// isolation after start, and reset (idle, mid-operation, and with start).
// Honors MULTU_RADIX4_EN for the expected iteration count.
module tb_multu_unit;

    localparam int W = 32;
`ifdef MULTU_RADIX4_EN
    localparam int ITERS = W / 2;
`else
    localparam int ITERS = W;
`endif
    localparam int BUSY_CYCLES = ITERS + 1;
    localparam logic [2:0] OP_MFHI = 3'b110;
    localparam logic [2:0] OP_MFLO = 3'b111;

    logic          clk;
    logic          rst;
    logic          start;
    logic [W-1:0]  dataA;
    logic [W-1:0]  dataB;
    logic [2:0]    Signal;
    logic          busy;
    logic          done;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;
    logic [W-1:0]  dataOut;

    int checkCount = 0;
    int passCount  = 0;
    // Model of the HI/LO pair contents
    logic [63:0] modelHiLo = 64'd0;

    multu_unit #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .dataA   (dataA),
        .dataB   (dataB),
        .Signal  (Signal),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo),
        .dataOut (dataOut)
    );

    // 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something wedges outside the bounded loops
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point for the whole bench
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", tag, observed, expected);
        end
    endtask

    // Wait for the next rising edge, then step just past it
    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Issue one MULTU and check timing, result and read mux. If interfereAt is
    // positive, new operands and a start pulse are driven at that busy cycle.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input int interfereAt, input string tag);
        logic [63:0] expProd;
        logic [31:0] gotHi;
        logic [31:0] gotLo;
        logic [31:0] midRead;
        int          cycles;
        int          doneCount;
        int          doneIdx;

        expProd   = {32'd0, a} * {32'd0, b};
        gotHi     = '0;
        gotLo     = '0;
        midRead   = '0;
        cycles    = 0;
        doneCount = 0;
        doneIdx   = 0;

        dataA  = a;
        dataB  = b;
        start  = 1'b1;
        Signal = OP_MFHI;
        stepCycle();
        start = 1'b0;

        while (busy && cycles < 200) begin
            cycles++;
            if (done) begin
                doneCount++;
                doneIdx = cycles;
                gotHi   = hi;
                gotLo   = lo;
            end
            if (cycles == 3) begin
                midRead = dataOut;
            end
            if (cycles == interfereAt) begin
                dataA = $urandom;
                dataB = $urandom;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            stepCycle();
        end
        start = 1'b0;

        checkOutput({tag, " busy_len"}, 64'(cycles), 64'(BUSY_CYCLES));
        checkOutput({tag, " done_count"}, 64'(doneCount), 64'd1);
        checkOutput({tag, " done_at"}, 64'(doneIdx), 64'(BUSY_CYCLES));
        checkOutput({tag, " hi_at_done"}, {32'd0, gotHi}, {32'd0, expProd[63:32]});
        checkOutput({tag, " lo_at_done"}, {32'd0, gotLo}, {32'd0, expProd[31:0]});
        checkOutput({tag, " mfhi_while_busy"}, {32'd0, midRead}, {32'd0, modelHiLo[63:32]});

        Signal = OP_MFHI;
        #1;
        checkOutput({tag, " mfhi"}, {32'd0, dataOut}, {32'd0, expProd[63:32]});
        Signal = OP_MFLO;
        #1;
        checkOutput({tag, " mflo"}, {32'd0, dataOut}, {32'd0, expProd[31:0]});
        Signal = 3'($urandom_range(0, 5));
        #1;
        checkOutput({tag, " other_op"}, {32'd0, dataOut}, 64'd0);

        modelHiLo = expProd;
    endtask

    initial begin
        int doneSeen;
        logic [31:0] ra;
        logic [31:0] rb;

        rst    = 1'b1;
        start  = 1'b0;
        dataA  = '0;
        dataB  = '0;
        Signal = OP_MFLO;
        stepCycle();
        stepCycle();
        rst = 1'b0;
        #1;
        checkOutput("reset busy", {63'd0, busy}, 64'd0);
        checkOutput("reset done", {63'd0, done}, 64'd0);
        checkOutput("reset hi", {32'd0, hi}, 64'd0);
        checkOutput("reset lo", {32'd0, lo}, 64'd0);
        checkOutput("reset dataOut", {32'd0, dataOut}, 64'd0);
        stepCycle();

        applyStimulus(32'd3, 32'd5, -1, "3x5");
        Signal = 3'b011;
        #1;
        checkOutput("3x5 op011", {32'd0, dataOut}, 64'd0);
        applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, -1, "max_x_max");
        applyStimulus(32'h80000000, 32'h00000002, -1, "msb_x_2");
        applyStimulus(32'd7, 32'd9, 10, "7x9_ignored_start");
        applyStimulus(32'd0, 32'hFFFFFFFF, -1, "zero_x_max");

        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 3))
                0: ra = 32'hFFFFFFFF;
                1: rb = 32'(1) << $urandom_range(0, 31);
                default: begin
                end
            endcase
            applyStimulus(ra, rb, -1, $sformatf("rand%0d", i));
        end

        // Leave a nonzero result in HI/LO so the reset clear is observable
        applyStimulus(32'hDEADBEEF, 32'h12345678, -1, "preload");

        // Reset in the middle of an operation
        dataA = 32'h1234;
        dataB = 32'h10;
        start = 1'b1;
        stepCycle();
        start = 1'b0;
        repeat (14) stepCycle();
        checkOutput("mid busy before rst", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        stepCycle();
        rst = 1'b0;
        checkOutput("mid rst busy", {63'd0, busy}, 64'd0);
        checkOutput("mid rst hi", {32'd0, hi}, 64'd0);
        checkOutput("mid rst lo", {32'd0, lo}, 64'd0);
        doneSeen = 0;
        repeat (40) begin
            if (done || busy) doneSeen++;
            stepCycle();
        end
        checkOutput("mid rst no done", 64'(doneSeen), 64'd0);
        modelHiLo = 64'd0;

        // Reset and start together: the start must be dropped
        rst   = 1'b1;
        start = 1'b1;
        dataA = 32'd5;
        dataB = 32'd5;
        stepCycle();
        rst   = 1'b0;
        start = 1'b0;
        checkOutput("rst+start busy", {63'd0, busy}, 64'd0);
        stepCycle();
        checkOutput("rst+start still idle", {63'd0, busy}, 64'd0);

        applyStimulus(32'd2, 32'd2, -1, "2x2_after_rst");

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
